// File: rtl/frame_bram_pkg.sv
// frame_bram_pkg: frame geometry, address width and fill sequencer states shared by the frame BRAM arbiter.
package frame_bram_pkg;
  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int FRAME_DEPTH = FRAME_W * FRAME_H;
  localparam int ADDR_W = 19;
  typedef enum logic {ST_IDLE, ST_FILL} fill_state_t;
endpackage

// File: rtl/bram_wr_fifo.sv
// bram_wr_fifo: small synchronous FIFO of {addr,data} client writes waiting for a free BRAM slot.
module bram_wr_fifo
  import frame_bram_pkg::*;
#(
  parameter int AW  = ADDR_W,
  parameter int LG2 = 2
) (
  input  logic          VGA_480_CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic          push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic          head_data,
  output logic          full,
  output logic          empty
);
  logic [AW:0]    mem [2**LG2];
  logic [LG2-1:0] wp, rp;
  logic [LG2:0]   cnt;
  logic           do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == (LG2+1)'(2**LG2);
  assign empty = cnt == '0;
  assign {head_addr, head_data} = mem[rp];
  always_ff @(posedge VGA_480_CLK)
    if (do_push) mem[wp] <= {push_addr, push_data};
  always_ff @(posedge VGA_480_CLK) begin
    if (RESET) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (LG2+1)'(do_push) - (LG2+1)'(do_pop);
    end
  end
endmodule

// File: rtl/frame_bram_arbiter.sv
// frame_bram_arbiter: shares the single-port frame BRAM between scan-out reads, a whole-frame fill and queued client writes.
module frame_bram_arbiter
  import frame_bram_pkg::*;
#(
  parameter int AW       = ADDR_W,
  parameter int DEPTH    = FRAME_DEPTH,
  parameter int FIFO_LG2 = 2
) (
  input  logic          VGA_480_CLK,
  input  logic          RESET,
  input  logic          disp_active,
  input  logic [AW-1:0] disp_addr,
  output logic          rd_valid,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  output logic          wr_ready,
  input  logic          fill_start,
  input  logic          fill_val,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [AW-1:0] bram_addr,
  output logic          bram_we,
  output logic          bram_din
);
  fill_state_t   state, state_n;
  logic [AW-1:0] fill_addr, head_addr;
  logic          fill_v, head_data, full, empty, done_q;
  logic          g_fill, g_pop, last, start;
  bram_wr_fifo #(.AW(AW), .LG2(FIFO_LG2)) u_fifo (
    .VGA_480_CLK(VGA_480_CLK),
    .RESET(RESET),
    .push(wr_valid),
    .push_addr(wr_addr),
    .push_data(wr_data),
    .pop(g_pop),
    .head_addr(head_addr),
    .head_data(head_data),
    .full(full),
    .empty(empty)
  );
  assign wr_ready = !full;
  assign fill_busy = state == ST_FILL;
  // Scan-out always wins; the fill starves the FIFO until the frame is done.
  always_comb begin
    g_fill = !disp_active && state == ST_FILL;
    g_pop = !disp_active && state == ST_IDLE && !empty;
    last = g_fill && fill_addr == AW'(DEPTH - 1);
    start = state == ST_IDLE && fill_start;
    state_n = start ? ST_FILL : last ? ST_IDLE : state;
  end
  always_ff @(posedge VGA_480_CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      fill_addr <= '0;
      fill_v <= 1'b0;
      done_q <= 1'b0;
      fill_done <= 1'b0;
      rd_valid <= 1'b0;
      bram_addr <= '0;
      bram_we <= 1'b0;
      bram_din <= 1'b0;
    end else begin
      state <= state_n;
      done_q <= last;
      fill_done <= done_q;
      if (start) begin
        fill_addr <= '0;
        fill_v <= fill_val;
      end else if (g_fill && !last) begin
        fill_addr <= fill_addr + 1'b1;
      end
      rd_valid <= disp_active;
      bram_we <= g_fill || g_pop;
      bram_addr <= disp_active ? disp_addr : g_fill ? fill_addr : head_addr;
      bram_din <= g_fill ? fill_v : g_pop && head_data;
    end
  end
endmodule
